// File: rtl/mem_block_mover.sv
// mem_block_mover
//   DMA-style helper that copies a run of bytes from one main-memory range to
//   another. It masters the MainMemory3232 bridge pins, one byte at a time:
//   read (Addr=src, Direction=1), turnaround, then write (Addr=dst, drive
//   MEMDATA, one-cycle active-low Load strobe). A destination in the ROM half
//   (Addr MSB = 0) aborts the transfer with Error.
//
// Ports
//   clk, rst             clock, synchronous active-high reset
//   Start                one-cycle request, sampled only in IDLE
//   SrcAddr/DstAddr      first source / destination address (latched on Start)
//   Length               byte count (latched on Start)
//   Busy                 transfer in progress
//   Done                 one-cycle completion pulse
//   Error                one-cycle pulse with Done on a ROM-destination abort
//   Addr                 registered memory address
//   MEMDATA              bidirectional data bus (driven only while writing)
//   MemBridge_Load       active-low RAM write strobe
//   MemBridge_Direction  high lets the memory drive MEMDATA
module mem_block_mover #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned LEN_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              Start,
  input  logic [ADDR_W-1:0] SrcAddr,
  input  logic [ADDR_W-1:0] DstAddr,
  input  logic [LEN_W-1:0]  Length,
  output logic              Busy,
  output logic              Done,
  output logic              Error,
  output logic [ADDR_W-1:0] Addr,
  inout  logic [DATA_W-1:0] MEMDATA,
  output logic              MemBridge_Load,
  output logic              MemBridge_Direction
);

  typedef enum logic [3:0] {
    IDLE,
    CHECK,
    RD_ADDR,
    RD_SAMPLE,
    TURN,
    WR_SETUP,
    WR_STROBE,
    WR_HOLD,
    FINISH
  } state_e;

  state_e              state_q;
  logic [ADDR_W-1:0]   src_q, dst_q;
  logic [ADDR_W-1:0]   src_d, dst_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic [DATA_W-1:0]   byte_q;
  logic [ADDR_W-1:0]   addr_q;
  logic                busy_q, done_q, err_q;
  logic                load_q, dir_q, drive_q;

  // Pointer advance after each byte; both addresses wrap modulo 2^ADDR_W.
  always_comb begin
    src_d = src_q + ADDR_W'(1);
    dst_d = dst_q + ADDR_W'(1);
    len_d = len_q - LEN_W'(1);
  end

  // Every output is assigned on the edge that enters the state it belongs
  // to, so each is visible for exactly the cycles the FSM sits in that state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      len_q   <= '0;
      byte_q  <= '0;
      addr_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      load_q  <= 1'b1;
      dir_q   <= 1'b0;
      drive_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (Start) begin
            src_q   <= SrcAddr;
            dst_q   <= DstAddr;
            len_q   <= Length;
            busy_q  <= 1'b1;
            state_q <= CHECK;
          end
        end
        CHECK: begin
          if (len_q == '0) begin
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= FINISH;
          end else if (!dst_q[ADDR_W-1]) begin
            // Also catches a destination that wrapped from the top of RAM.
            done_q  <= 1'b1;
            err_q   <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= FINISH;
          end else begin
            addr_q  <= src_q;
            dir_q   <= 1'b1;
            state_q <= RD_ADDR;
          end
        end
        RD_ADDR: begin
          state_q <= RD_SAMPLE;
        end
        RD_SAMPLE: begin
          byte_q  <= MEMDATA;
          dir_q   <= 1'b0;
          state_q <= TURN;
        end
        TURN: begin
          addr_q  <= dst_q;
          drive_q <= 1'b1;
          load_q  <= 1'b1;
          state_q <= WR_SETUP;
        end
        WR_SETUP: begin
          load_q  <= 1'b0;
          state_q <= WR_STROBE;
        end
        WR_STROBE: begin
          load_q  <= 1'b1;
          state_q <= WR_HOLD;
        end
        WR_HOLD: begin
          drive_q <= 1'b0;
          src_q   <= src_d;
          dst_q   <= dst_d;
          len_q   <= len_d;
          state_q <= CHECK;
        end
        FINISH: begin
          done_q  <= 1'b0;
          err_q   <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign Busy                = busy_q;
  assign Done                = done_q;
  assign Error               = err_q;
  assign Addr                = addr_q;
  assign MemBridge_Load      = load_q;
  assign MemBridge_Direction = dir_q;
  assign MEMDATA             = drive_q ? byte_q : 'z;

endmodule

// File: tb/tb_mem_block_mover.sv
// Scoreboard bench for mem_block_mover: directed transfers push expected
// writes and completions into queues; a negedge monitor pops and compares
// whenever the DUT strobes a write or pulses Done. A behavioural memory
// answers reads and records RAM writes; a pull-up makes an undriven bus
// read as 8'hFF.
module tb_mem_block_mover;

  logic        clk = 1'b0;
  logic        rst;
  logic        Start;
  logic [15:0] SrcAddr, DstAddr, Length;
  logic        Busy, Done, Error;
  logic [15:0] Addr;
  logic        MemBridge_Load, MemBridge_Direction;
  wire  [7:0]  MEMDATA;

  logic [7:0]  mem [0:65535];

  pullup pu_memdata (MEMDATA);
  assign MEMDATA = MemBridge_Direction ? mem[Addr] : 8'bz;

  mem_block_mover #(.ADDR_W(16), .DATA_W(8), .LEN_W(16)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .Start               (Start),
    .SrcAddr             (SrcAddr),
    .DstAddr             (DstAddr),
    .Length              (Length),
    .Busy                (Busy),
    .Done                (Done),
    .Error               (Error),
    .Addr                (Addr),
    .MEMDATA             (MEMDATA),
    .MemBridge_Load      (MemBridge_Load),
    .MemBridge_Direction (MemBridge_Direction)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  typedef struct { logic [15:0] a; logic [7:0] d; } wr_t;
  typedef struct { int unsigned cyc; logic err; } done_t;

  wr_t   exp_wr[$];
  done_t exp_done[$];

  logic        mon_en = 1'b0;
  logic        prev_strobe = 1'b0;
  logic [15:0] strobe_a, prev_a;
  logic [7:0]  strobe_d, prev_d;
  int unsigned dir_cnt = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic push_wr(input logic [15:0] a, input logic [7:0] d);
    wr_t w;
    w.a = a;
    w.d = d;
    exp_wr.push_back(w);
  endtask

  // Raises Start for one cycle; nbytes is the number of bytes expected to be
  // written before completion (7 cycles each, plus final CHECK and FINISH).
  task automatic start_xfer(input logic [15:0] s, input logic [15:0] d, input logic [15:0] l,
                            input logic exp_err, input int unsigned nbytes, input logic push_done);
    done_t t;
    @(negedge clk);
    Start = 1'b1; SrcAddr = s; DstAddr = d; Length = l;
    if (push_done) begin
      t.cyc = cyc + 7 * nbytes + 2;
      t.err = exp_err;
      exp_done.push_back(t);
    end
    @(negedge clk);
    Start = 1'b0;
    chk("busy_after_start", {31'b0, Busy}, 32'd1);
  endtask

  task automatic wait_done(input int unsigned limit);
    int unsigned n;
    n = 0;
    while (exp_done.size() != 0 && n < limit) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (exp_done.size() != 0) begin
      errors++;
      $display("FAIL done_timeout: %0d completions outstanding after %0d cycles, expected 0",
               exp_done.size(), limit);
      exp_done.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  // Monitor / scoreboard
  always @(negedge clk) begin : monitor
    wr_t   w;
    done_t dn;
    if (mon_en) begin
      if (MemBridge_Direction) begin
        dir_cnt++;
        chk("read_bus_uncontended", {24'b0, MEMDATA}, {24'b0, mem[Addr]});
      end
      if (prev_strobe) begin
        chk("wr_hold_addr", {16'b0, Addr}, {16'b0, strobe_a});
        chk("wr_hold_data", {24'b0, MEMDATA}, {24'b0, strobe_d});
      end
      prev_strobe = 1'b0;
      if (!MemBridge_Load) begin
        chk("wr_strobe_dir_low", {31'b0, MemBridge_Direction}, 32'd0);
        chk("wr_setup_addr", {16'b0, prev_a}, {16'b0, Addr});
        chk("wr_setup_data", {24'b0, prev_d}, {24'b0, MEMDATA});
        if (exp_wr.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: addr=%04h data=%02h, expected no write", Addr, MEMDATA);
        end else begin
          w = exp_wr.pop_front();
          chk("wr_addr", {16'b0, Addr}, {16'b0, w.a});
          chk("wr_data", {24'b0, MEMDATA}, {24'b0, w.d});
        end
        if (Addr[15]) mem[Addr] = MEMDATA;
        prev_strobe = 1'b1;
        strobe_a = Addr;
        strobe_d = MEMDATA;
      end
      if (Done) begin
        if (exp_done.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: Done=1 Error=%0b, expected no completion", Error);
        end else begin
          dn = exp_done.pop_front();
          chk("done_cycle", cyc, dn.cyc);
          chk("done_error", {31'b0, Error}, {31'b0, dn.err});
          chk("busy_at_done", {31'b0, Busy}, 32'd0);
        end
      end else if (Error) begin
        checks++;
        errors++;
        $display("FAIL error_without_done: Error=1, expected 0");
      end
    end
    prev_a = Addr;
    prev_d = MEMDATA;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1);
  end

  initial begin : stim
    int unsigned d0;
    for (int i = 0; i < 65536; i++) begin
      logic [15:0] a;
      a = 16'(i);
      mem[i] = a[15] ? 8'h00 : (a[7:0] + 8'h11);
    end
    rst = 1'b1; Start = 1'b0; SrcAddr = '0; DstAddr = '0; Length = '0;
    repeat (3) @(negedge clk);

    // Reset state
    chk("rst_busy",  {31'b0, Busy}, 32'd0);
    chk("rst_done",  {31'b0, Done}, 32'd0);
    chk("rst_error", {31'b0, Error}, 32'd0);
    chk("rst_addr",  {16'b0, Addr}, 32'd0);
    chk("rst_load",  {31'b0, MemBridge_Load}, 32'd1);
    chk("rst_dir",   {31'b0, MemBridge_Direction}, 32'd0);
    chk("rst_bus_z", {24'b0, MEMDATA}, 32'hFF);
    rst = 1'b0;
    mon_en = 1'b1;

    // ROM 0..3 -> RAM 0x8000, with a stray Start while busy
    push_wr(16'h8000, 8'h11); push_wr(16'h8001, 8'h12);
    push_wr(16'h8002, 8'h13); push_wr(16'h8003, 8'h14);
    start_xfer(16'h0000, 16'h8000, 16'd4, 1'b0, 4, 1'b1);
    repeat (3) @(negedge clk);
    Start = 1'b1; SrcAddr = 16'h0040; DstAddr = 16'h9000; Length = 16'd1;
    @(negedge clk);
    Start = 1'b0;
    wait_done(60);
    chk("ignored_start_no_write", {24'b0, mem[16'h9000]}, 32'd0);
    chk("s1_writes_drained", exp_wr.size(), 32'd0);

    // Length = 0: no bus activity
    d0 = dir_cnt;
    start_xfer(16'h0000, 16'h8000, 16'd0, 1'b0, 0, 1'b1);
    wait_done(10);
    chk("len0_no_read", dir_cnt - d0, 32'd0);

    // ROM destination: immediate abort
    d0 = dir_cnt;
    start_xfer(16'h0000, 16'h0010, 16'd3, 1'b1, 0, 1'b1);
    wait_done(10);
    chk("romdst_no_read", dir_cnt - d0, 32'd0);

    // Destination wraps into ROM after two bytes
    push_wr(16'hFFFE, 8'h11); push_wr(16'hFFFF, 8'h12);
    start_xfer(16'h8000, 16'hFFFE, 16'd4, 1'b1, 2, 1'b1);
    wait_done(40);
    chk("wrap_writes_drained", exp_wr.size(), 32'd0);

    // Reset during byte 2 of a 5-byte copy: only byte 1 lands
    push_wr(16'h8100, 8'h15);
    start_xfer(16'h0004, 16'h8100, 16'd5, 1'b0, 0, 1'b0);
    repeat (11) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_load", {31'b0, MemBridge_Load}, 32'd1);
    chk("midrst_dir",  {31'b0, MemBridge_Direction}, 32'd0);
    chk("midrst_bus_z", {24'b0, MEMDATA}, 32'hFF);
    chk("midrst_busy", {31'b0, Busy}, 32'd0);
    chk("midrst_done", {31'b0, Done}, 32'd0);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    chk("midrst_writes_drained", exp_wr.size(), 32'd0);

    // Fresh transfer after the reset
    push_wr(16'h8300, 8'h31); push_wr(16'h8301, 8'h32);
    start_xfer(16'h0020, 16'h8300, 16'd2, 1'b0, 2, 1'b1);
    wait_done(30);

    // Overlapping forward copy smears the first byte
    push_wr(16'h8001, 8'h11); push_wr(16'h8002, 8'h11); push_wr(16'h8003, 8'h11);
    start_xfer(16'h8000, 16'h8001, 16'd3, 1'b0, 3, 1'b1);
    wait_done(40);

    // Source wraps 0xFFFF -> 0x0000
    push_wr(16'h8400, 8'h12); push_wr(16'h8401, 8'h11);
    start_xfer(16'hFFFF, 16'h8400, 16'd2, 1'b0, 2, 1'b1);
    wait_done(30);

    // Reset and Start together: Start is dropped
    @(negedge clk);
    rst = 1'b1; Start = 1'b1; SrcAddr = 16'h0000; DstAddr = 16'h8500; Length = 16'd1;
    @(negedge clk);
    rst = 1'b0; Start = 1'b0;
    chk("rst_start_busy", {31'b0, Busy}, 32'd0);
    @(negedge clk);
    chk("rst_start_still_idle", {31'b0, Busy}, 32'd0);
    repeat (12) @(negedge clk);

    chk("final_writes_drained", exp_wr.size(), 32'd0);
    chk("final_done_drained", exp_done.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
